// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, register selector and the IF/ID queue entry.
package cpu_types_pkg;

  localparam int unsigned WORD_BITS = 32;
  localparam int unsigned REG_BITS  = 5;

  typedef logic [WORD_BITS-1:0] word_t;
  typedef logic [REG_BITS-1:0]  regbits_t;

  typedef struct packed {
    word_t    instr;
    word_t    npc;
    regbits_t rsel1;
    regbits_t rsel2;
  } ifid_entry_t;

endpackage

// File: rtl/ifid_queue_if.sv
// Fetch/decode handshake bundle around the IF/ID queue; modports are seen from the queue side.
interface ifid_queue_if;
  import cpu_types_pkg::*;

  logic        if_valid;
  logic        if_ready;
  ifid_entry_t if_entry;
  logic        id_valid;
  logic        id_ready;
  ifid_entry_t id_entry;

  modport fetch (input if_valid, input if_entry, output if_ready);
  modport decode (output id_valid, output id_entry, input id_ready);

endinterface

// File: rtl/ifid_queue_ctrl.sv
// Pointer/occupancy control for the IF/ID queue: handshakes, full/empty and flush priority.
module ifid_queue_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  ifid_queue_if.fetch      fetch_bus,
  ifid_queue_if.decode     decode_bus,
  output logic             wr_en,
  output logic [PTR_W-1:0] wptr,
  output logic [PTR_W-1:0] rptr,
  output logic [PTR_W:0]   count
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic             ready_q;
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push;
  logic             pop;

  // if_ready comes from registers only, so a full queue never accepts on a same-cycle pop.
  assign fetch_bus.if_ready  = ready_q && (count_q != FULL_CNT);
  assign decode_bus.id_valid = (count_q != '0);

  assign push = fetch_bus.if_valid && fetch_bus.if_ready && !flush;
  assign pop  = decode_bus.id_valid && decode_bus.id_ready && !flush;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ready_q <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      ready_q <= 1'b1;
      if (flush) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  assign wr_en = push;
  assign wptr  = wptr_q;
  assign rptr  = rptr_q;
  assign count = count_q;

endmodule

// File: rtl/ifid_queue.sv
// DEPTH-entry in-order IF/ID instruction queue; register selects are captured at enqueue and an
// empty queue presents an all-zero bubble to decode.
module ifid_queue
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned RSEL_W = 5,
  parameter int unsigned RS_LSB = 21,
  parameter int unsigned RT_LSB = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     if_valid,
  output logic                     if_ready,
  input  logic [WORD_W-1:0]        if_instr,
  input  logic [WORD_W-1:0]        if_npc,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [WORD_W-1:0]        id_instr,
  output logic [WORD_W-1:0]        id_npc,
  output logic [RSEL_W-1:0]        id_rsel1,
  output logic [RSEL_W-1:0]        id_rsel2,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  ifid_queue_if bus ();

  ifid_entry_t      mem [DEPTH];
  logic             wr_en;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;

  assign bus.if_valid = if_valid;
  assign bus.if_entry = '{
    instr: if_instr,
    npc:   if_npc,
    rsel1: if_instr[RS_LSB +: RSEL_W],
    rsel2: if_instr[RT_LSB +: RSEL_W]
  };
  assign bus.id_ready = id_ready;

  ifid_queue_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ctrl (
    .CLK        (CLK),
    .RST        (RST),
    .flush      (flush),
    .fetch_bus  (bus.fetch),
    .decode_bus (bus.decode),
    .wr_en      (wr_en),
    .wptr       (wptr),
    .rptr       (rptr),
    .count      (count)
  );

  // Storage needs no reset: nothing is read until count says the slot was written.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wptr] <= bus.if_entry;
  end

  always_comb begin
    bus.id_entry = '0;
    if (bus.id_valid) bus.id_entry = mem[rptr];
  end

  assign if_ready = bus.if_ready;
  assign id_valid = bus.id_valid;
  assign id_instr = bus.id_entry.instr;
  assign id_npc   = bus.id_entry.npc;
  assign id_rsel1 = bus.id_entry.rsel1;
  assign id_rsel2 = bus.id_entry.rsel2;

endmodule

// File: doc/ifid_queue.md
Name: ifid_queue

Overview:
Parametrised successor to the single-entry fetch/decode pipeline register. It is a DEPTH-entry in-order instruction queue between fetch and decode, with a valid/ready handshake on both sides. Per-entry register-select extraction happens at enqueue. A flush empties the queue in one cycle, and the decode side sees a zero-instruction bubble when the queue is empty.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
WORD_W, 32, instruction and address width
RSEL_W, 5, register-select field width
RS_LSB, 21, LSB of the rs field within the instruction (rs = instr[RS_LSB+RSEL_W-1:RS_LSB])
RT_LSB, 16, LSB of the rt field within the instruction

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
if_valid  in  1  fetch presents an instruction this cycle
if_ready  out  1  queue can accept an instruction
if_instr  in  WORD_W  fetched instruction
if_npc  in  WORD_W  next-PC / JAL return address travelling with the instruction
id_valid  out  1  head entry is valid
id_ready  in  1  decode consumes the head this cycle
id_instr  out  WORD_W  head instruction; 0 when empty
id_npc  out  WORD_W  head next-PC; 0 when empty
id_rsel1  out  RSEL_W  head rs field; 0 when empty
id_rsel2  out  RSEL_W  head rt field; 0 when empty
flush  in  1  discard all entries (branch/jump redirect)
count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (RST high, asynchronous):
  - Read pointer, write pointer and count clear to 0.
  - Storage contents are don't-care.
  - id_valid = 0; id_instr/id_npc/id_rsel1/id_rsel2 = 0.
  - if_ready = 0 while RST is high, 1 from the first cycle after release.
- Push: if_valid && if_ready at a rising edge.
  - Writes {if_instr, if_npc, rs field, rt field} at the write pointer; write pointer increments.
  - rsel fields are extracted at enqueue time and stored, not recomputed at dequeue.
- Pop: id_valid && id_ready at a rising edge.
  - Read pointer increments.
  - id_ready while id_valid=0 has no effect.
- if_ready = (count != DEPTH), derived only from registered state; no combinational path from id_ready to if_ready.
  - When full, a simultaneous pop does not allow a same-cycle push.
- Head outputs:
  - id_valid = (count != 0).
  - id_* are the read-pointer entry, forced to 0 when count == 0, so an empty queue presents a NOP bubble.
- Latency: an instruction pushed at edge N is visible on id_* after edge N (one cycle). There is no same-cycle bypass from if_* to id_*.
- Count update: count' = count + push - pop. Simultaneous push and pop (count strictly between 0 and DEPTH) leaves count unchanged and advances both pointers.
- Pointers: $clog2(DEPTH) bits, wrapping naturally from DEPTH-1 to 0.
- Flush, synchronous, highest priority:
  - Pointers and count clear to 0; any same-cycle push or pop is ignored.
  - The next cycle shows id_valid = 0 and id_* = 0.
  - if_ready stays 1 during flush.
- Never overflow or underflow: count stays in [0, DEPTH]. Bench assertions must flag any violation.
- Reset mid-operation: all state clears immediately; outputs go to their reset values without waiting for CLK.

Decomposition:
- cpu_types_pkg gains:
  - `word_t` (existing)
  - `regbits_t` (existing)
  - a packed struct `ifid_entry_t` {instr, npc, rsel1, rsel2}, shared with the future ID/EX queue
- The module takes an interface `ifid_queue_if` with `fetch` and `decode` modports.
- A single natural sub-module, `ifid_queue_ctrl`, holds the pointers, count, full/empty and flush priority. Storage and the output mux stay in the top module.

Test Plan:
- Reset release, then push 0x8C220004/npc 0x4 -> next cycle id_valid=1, id_instr=0x8C220004, id_rsel1=1, id_rsel2=2, id_npc=0x4, count=1.
- Push 4 entries with id_ready=0 (DEPTH=4) -> count=4, if_ready=0; a 5th if_valid is not accepted; draining then yields the 4 instructions in order.
- Full queue, id_ready=1 and if_valid=1 in the same cycle -> pop only, count=3, no push; the next cycle both are accepted and count stays 3.
- Wrap-around: 10 continuous push/pop cycles with incrementing instructions 1..10 -> decode sees 1..10 in order, count steady at 1.
- Flush with count=3 and simultaneous if_valid=1 -> next cycle count=0, id_valid=0, id_instr=0; the instruction offered during flush is lost.
- Assert RST asynchronously mid-stream with count=2 -> id_valid=0 and if_ready=0 immediately; after release count=0 and if_ready=1.
